data_mem_access_unit: RTL
=========================

// Module: data_mem_access_unit
// PURPOSE
//  Initiator side of the Data_Memory block-RAM port (clka/wea/addra/dina/douta).
//  Accepts one load/store request at a time from the KGP-RISC datapath.
//  Drives byte-lane write enables, waits out the BRAM read latency, and
//  extracts/extends sub-word load data. Returns one response per request.
// PARAMETERS
//  READ_LAT  1  clock edges from address sample to valid douta (1..3)
// PORTS
//  clk        in   1   single clock; also drives Data_Memory clka
//  rst        in   1   asynchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   unit can accept; high only in IDLE and rst low
//  req_we     in   1   1 = store, 0 = load
//  req_size   in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_sign   in   1   loads: 1 sign-extend, 0 zero-extend
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-aligned
//  mem_wea    out  4   byte write enables to Data_Memory; bit i = byte lane i
//  mem_addra  out  32  word address = {2'b00, addr[31:2]}
//  mem_dina   out  32  lane-replicated store data
//  mem_douta  in   32  read data from Data_Memory
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   consumer accepts response
//  rsp_rdata  out  32  load result; 0 for stores and errors
//  rsp_err    out  1   misaligned or reserved-size request
// BEHAVIOUR
//  Reset (async): state IDLE, READ_LAT counter 0, all registered outputs 0.
//  The 0 outputs are mem_wea, mem_addra, mem_dina, rsp_valid, rsp_rdata and rsp_err.
//  Little-endian lanes; lane = addr[1:0].
//  FSM states:
//   IDLE: req_ready=1. On req_valid, latch all req_* fields.
//    On error, go to RESP with no memory access.
//    Otherwise go to ISSUE.
//   ISSUE (1 cycle): drive mem_addra. For a store, also drive mem_wea and mem_dina.
//    Store -> RESP. Load -> WAIT.
//   WAIT (READ_LAT cycles): mem_wea=0 and mem_addra held.
//    On the last WAIT edge, capture mem_douta, extract the lane and extend. Then -> RESP.
//   RESP: rsp_valid=1; rsp_* stable while rsp_ready=0.
//    On rsp_ready -> IDLE, rsp_valid=0 the next cycle.
//  mem_wea is nonzero only during ISSUE of a valid store; it is 0 everywhere else.
//  Error rules: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
//   Result: rsp_err=1, rsp_rdata=0.
//  Store encoding:
//   byte: wea = 0001<<lane, dina = {4{wdata[7:0]}}
//   half: wea = 0011<<{addr[1],0}, dina = {2{wdata[15:0]}}
//   word: wea = 1111, dina = wdata
//  Load: select the byte/half lane. Extend to 32 bits from bit 7/15 when req_sign=1, else zero.
//  Latency from the accept edge T: store rsp_valid at T+2; load at T+2+READ_LAT.
//   Back-to-back throughput: one request per (latency + 1) cycles.
//  req_valid during non-IDLE states is ignored (req_ready=0). No request is dropped.
//  Reset mid-operation: returns to IDLE at once and mem_wea drops asynchronously.
//   No response is produced; the first request after rst falls is serviced normally.
// TESTING
//  1 Store word 0xDEADBEEF @0x10 -> one cycle of wea=1111, addra=4, dina=DEADBEEF.
//    Then rsp_valid at T+2 with err=0.
//  2 Signed byte load @0x13 -> rdata=0xFFFFFFDE. Unsigned -> 0x000000DE.
//  3 Store half 0x1234 @0x12 -> wea=1100, dina=0x12341234.
//    Then word load @0x10 -> 0x1234BEEF.
//  4 Word load @0x11 -> rsp_err=1, rdata=0, wea stays 0000, rsp_valid at T+1.
//  5 Hold rsp_ready=0 for 5 cycles on a load -> rsp_valid/rdata stable, req_ready=0.
//    No second accept until release.
//  6 Assert rst during WAIT (also READ_LAT=2 build) -> rsp_valid=0, wea=0.
//    The next store then completes correctly.

Source files
------------

// File: rtl/data_mem_access_unit_if.sv
// Request/response and Data_Memory port bundle for data_mem_access_unit.
// master: datapath + BRAM side; slave: the access unit.
interface data_mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addra;
  logic [31:0] mem_dina;
  logic [31:0] mem_douta;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_sign, req_addr, req_wdata,
    input  req_ready,
    input  mem_wea, mem_addra, mem_dina,
    output mem_douta,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_sign, req_addr, req_wdata,
    output req_ready,
    output mem_wea, mem_addra, mem_dina,
    input  mem_douta,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// Load/store initiator for the Data_Memory BRAM port.
// Ports: clk, rst (async high), bus (slave modport: req/mem/rsp).
module data_mem_access_unit #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  data_mem_access_unit_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  wea_q, wea_d;
  logic [31:0] addra_q, addra_d;
  logic [31:0] dina_q, dina_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;

  logic        req_err;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = |bus.req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Lane masks/replicated data are formed from the live request
  // so they are already registered when ISSUE begins.
  always_comb begin
    st_mask = 4'b0000;
    st_data = 32'h0;
    case (bus.req_size)
      2'b00: begin
        st_mask = 4'b0001 << bus.req_addr[1:0];
        st_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        st_mask = 4'b1111;
        st_data = bus.req_wdata;
      end
      default: begin
        st_mask = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'h0;
    case (lane_q)
      2'd0:    ld_byte = bus.mem_douta[7:0];
      2'd1:    ld_byte = bus.mem_douta[15:8];
      2'd2:    ld_byte = bus.mem_douta[23:16];
      default: ld_byte = bus.mem_douta[31:24];
    endcase
    ld_half = lane_q[1] ? bus.mem_douta[31:16]
                        : bus.mem_douta[15:0];
    ld_data = bus.mem_douta;
    case (size_q)
      2'b00:   ld_data = {{24{sign_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{sign_q & ld_half[15]}}, ld_half};
      default: ld_data = bus.mem_douta;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    sign_d   = sign_q;
    lane_d   = lane_q;
    wea_d    = wea_q;
    addra_d  = addra_q;
    dina_d   = dina_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d   = bus.req_we;
          size_d = bus.req_size;
          sign_d = bus.req_sign;
          lane_d = bus.req_addr[1:0];
          if (req_err) begin
            err_d    = 1'b1;
            rdata_d  = 32'h0;
            rvalid_d = 1'b1;
            state_d  = S_RESP;
          end else begin
            addra_d = {2'b00, bus.req_addr[31:2]};
            wea_d   = bus.req_we ? st_mask : 4'b0000;
            dina_d  = bus.req_we ? st_data : 32'h0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wea_d = 4'b0000;
        if (we_q) begin
          err_d    = 1'b0;
          rdata_d  = 32'h0;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d   = 2'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'(READ_LAT - 1)) begin
          err_d    = 1'b0;
          rdata_d  = ld_data;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        if (bus.rsp_ready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      sign_q   <= 1'b0;
      lane_q   <= 2'b00;
      wea_q    <= 4'b0000;
      addra_q  <= 32'h0;
      dina_q   <= 32'h0;
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      lane_q   <= lane_d;
      wea_q    <= wea_d;
      addra_q  <= addra_d;
      dina_q   <= dina_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE) && !rst;
  assign bus.mem_wea   = wea_q;
  assign bus.mem_addra = addra_q;
  assign bus.mem_dina  = dina_q;
  assign bus.rsp_valid = rvalid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule
